// File: rtl/i2c_slave_regs.sv
// I2C target with glitch-filtered SCL/SDA, 7-bit address match and an
// auto-incrementing register pointer exposed through a simple register port.
module i2c_slave_regs #(
   parameter logic [6:0] SLAVE_ADDR = 7'h3e,
   parameter int         FILTER_LEN = 3
) (
   input  logic       clk,
   input  logic       res,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   input  logic [7:0] reg_rdata,
   output logic       reg_rd,
   output logic       busy,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ACK_A, S_WR_PTR, S_WR_DATA,
      S_ACK_W, S_RD_BYTE, S_RD_ACK, S_IGNORE
   } state_t;

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // index 0 = SCL, index 1 = SDA
   logic [1:0]    sync1, sync2, filt, filt_q;
   logic [CW-1:0] fcnt [2];

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         sync1  <= '1;
         sync2  <= '1;
         filt   <= '1;
         filt_q <= '1;
         for (int i = 0; i < 2; i++) fcnt[i] <= '0;
      end else begin
         sync1  <= {sda_in, scl_in};
         sync2  <= sync1;
         filt_q <= filt;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == CNT_LAST) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + CNT_ONE;
            end
         end
      end
   end

   logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
   assign scl_f    = filt[0];
   assign sda_f    = filt[1];
   assign scl_rise = filt[0] & ~filt_q[0];
   assign scl_fall = ~filt[0] & filt_q[0];
   assign start_c  = ~filt[1] & filt_q[1] & scl_f;
   assign stop_c   = filt[1] & ~filt_q[1] & scl_f;

   state_t     state, state_d;
   logic [3:0] bit_cnt, bit_cnt_d;
   logic [7:0] shreg, shreg_d, shift_in;
   logic [7:0] reg_addr_d, reg_wdata_d;
   logic       ack_on, ack_on_d, rw, rw_d;
   logic       sda_oe_d, busy_d, reg_wr_d, rd_load;

   assign shift_in  = {shreg[6:0], sda_f};
   assign reg_rd    = rd_load;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         ack_on    <= 1'b0;
         rw        <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_wr    <= 1'b0;
      end else begin
         state     <= state_d;
         bit_cnt   <= bit_cnt_d;
         shreg     <= shreg_d;
         ack_on    <= ack_on_d;
         rw        <= rw_d;
         sda_oe    <= sda_oe_d;
         busy      <= busy_d;
         reg_addr  <= reg_addr_d;
         reg_wdata <= reg_wdata_d;
         reg_wr    <= reg_wr_d;
      end
   end

   always_comb begin
      state_d     = state;
      bit_cnt_d   = bit_cnt;
      shreg_d     = shreg;
      ack_on_d    = ack_on;
      rw_d        = rw;
      sda_oe_d    = sda_oe;
      busy_d      = busy;
      reg_addr_d  = reg_addr;
      reg_wdata_d = reg_wdata;
      reg_wr_d    = 1'b0;
      rd_load     = 1'b0;
      // pointer advances the clk after each write strobe
      if (reg_wr) reg_addr_d = reg_addr + 8'd1;
      if (start_c) begin
         state_d   = S_ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         ack_on_d  = 1'b0;
      end else if (stop_c) begin
         state_d  = S_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
         ack_on_d = 1'b0;
      end else begin
         case (state)
            S_ADDR, S_WR_PTR, S_WR_DATA: begin
               if (scl_rise) begin
                  shreg_d   = shift_in;
                  bit_cnt_d = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt_d = '0;
                     ack_on_d  = 1'b0;
                     if (state == S_ADDR) begin
                        if (shift_in[7:1] == SLAVE_ADDR) begin
                           state_d = S_ACK_A;
                           rw_d    = shift_in[0];
                           busy_d  = 1'b1;
                        end else begin
                           state_d = S_IGNORE;
                        end
                     end else if (state == S_WR_PTR) begin
                        reg_addr_d = shift_in;
                        state_d    = S_ACK_W;
                     end else begin
                        reg_wdata_d = shift_in;
                        reg_wr_d    = 1'b1;
                        state_d     = S_ACK_W;
                     end
                  end
               end
            end
            S_ACK_A, S_ACK_W: begin
               // first fall pulls SDA low, second fall ends the ACK clock
               if (scl_fall) begin
                  if (!ack_on) begin
                     sda_oe_d = 1'b1;
                     ack_on_d = 1'b1;
                  end else begin
                     ack_on_d = 1'b0;
                     if (state == S_ACK_A && rw) begin
                        rd_load = 1'b1;
                     end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = (state == S_ACK_A) ? S_WR_PTR : S_WR_DATA;
                     end
                  end
               end
            end
            S_RD_BYTE: begin
               if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_oe_d = 1'b0;
                     ack_on_d = 1'b0;
                     state_d  = S_RD_ACK;
                  end else begin
                     sda_oe_d  = ~shreg[6];
                     shreg_d   = {shreg[6:0], 1'b0};
                     bit_cnt_d = bit_cnt + 4'd1;
                  end
               end
            end
            S_RD_ACK: begin
               if (scl_rise && !ack_on) begin
                  if (!sda_f) begin
                     reg_addr_d = reg_addr + 8'd1;
                     ack_on_d   = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = S_IGNORE;
                  end
               end else if (scl_fall && ack_on) begin
                  ack_on_d = 1'b0;
                  rd_load  = 1'b1;
               end
            end
            S_IGNORE: sda_oe_d = 1'b0;
            S_IDLE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
         // capture read data and put its MSB on the bus in the same clk
         if (rd_load) begin
            shreg_d   = reg_rdata;
            sda_oe_d  = ~reg_rdata[7];
            bit_cnt_d = 4'd1;
            state_d   = S_RD_BYTE;
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-level I2C master on an open-drain
// bus, register-write scoreboard and read-data checks.
module tb_i2c_slave_regs;

   localparam int Q = 8;
   localparam logic [3:0] ST_IDLE = 4'd0;

   logic       clk = 1'b0;
   logic       res;
   logic       m_scl, m_sda;
   logic       sda_bus;
   logic       sda_oe;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_wr, reg_rd, busy;
   logic [3:0] state_dbg;

   int total = 0;
   int bad   = 0;
   int wr_seen = 0, rd_seen = 0, oe_seen = 0;

   logic [15:0] exp_wr_q[$];
   logic [7:0]  exp_rd_q[$];
   logic [7:0]  model_ptr;

   always #5 clk = ~clk;

   assign sda_bus   = sda_oe ? 1'b0 : m_sda;
   assign reg_rdata = reg_addr ^ 8'hff;

   i2c_slave_regs dut (
      .clk       (clk),
      .res       (res),
      .scl_in    (m_scl),
      .sda_in    (sda_bus),
      .sda_oe    (sda_oe),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rdata (reg_rdata),
      .reg_rd    (reg_rd),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // register-port monitor and write scoreboard
   logic       wr_prev = 1'b0;
   logic [7:0] wr_prev_addr = '0;
   logic [7:0] inc_exp;
   logic [15:0] wr_exp;
   always @(negedge clk) begin
      if (!res) begin
         wr_prev = 1'b0;
      end else begin
         if (wr_prev) begin
            inc_exp = wr_prev_addr + 8'd1;
            check("addr_inc_after_wr", {24'd0, reg_addr}, {24'd0, inc_exp});
         end
         if (reg_wr) begin
            wr_exp = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : 16'hxxxx;
            check("reg_wr_addr_data", {16'd0, reg_addr, reg_wdata}, {16'd0, wr_exp});
            wr_seen++;
         end
         wr_prev      = reg_wr;
         wr_prev_addr = reg_addr;
         if (reg_rd) rd_seen++;
         if (sda_oe) oe_seen++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic q_wait();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; q_wait();
      m_scl = 1'b1; q_wait();
      m_sda = 1'b0; q_wait();
      m_scl = 1'b0; q_wait();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; q_wait();
      m_scl = 1'b1; q_wait();
      m_sda = 1'b1; q_wait();
   endtask

   task automatic send_bit(input logic b, output logic s);
      m_sda = b;    q_wait();
      m_scl = 1'b1; q_wait();
      s = sda_bus;  q_wait();
      m_scl = 1'b0; q_wait();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(d[i], s);
      send_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic m_ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         d[i] = s;
      end
      send_bit(m_ack, s);
   endtask

   task automatic wr_data(input logic [7:0] d);
      logic ack;
      exp_wr_q.push_back({model_ptr, d});
      model_ptr++;
      write_byte(d, ack);
      check("wdata_ack", {31'd0, ack}, 32'd0);
   endtask

   task automatic write_txn(input logic [7:0] ptr, input logic [7:0] d0, input logic [7:0] d1);
      logic ack;
      int   w0;
      w0 = wr_seen;
      i2c_start();
      write_byte(8'h7c, ack);
      check("addr_ack", {31'd0, ack}, 32'd0);
      check("busy_after_match", {31'd0, busy}, 32'd1);
      write_byte(ptr, ack);
      check("ptr_ack", {31'd0, ack}, 32'd0);
      model_ptr = ptr;
      wr_data(d0);
      wr_data(d1);
      i2c_stop();
      q_wait();
      check("wr_count", wr_seen - w0, 32'd2);
      check("ptr_after_write", {24'd0, reg_addr}, {24'd0, model_ptr});
      check("busy_after_stop", {31'd0, busy}, 32'd0);
      check("wr_q_empty", exp_wr_q.size(), 32'd0);
   endtask

   logic       ack;
   logic [7:0] rbyte, rexp;
   int         oe0, wr0, rd0;

   initial begin
      res = 1'b0; m_scl = 1'b1; m_sda = 1'b1; model_ptr = '0;
      repeat (5) @(posedge clk);
      #1;
      check("rst_sda_oe",    {31'd0, sda_oe},    32'd0);
      check("rst_reg_wr",    {31'd0, reg_wr},    32'd0);
      check("rst_reg_rd",    {31'd0, reg_rd},    32'd0);
      check("rst_reg_addr",  {24'd0, reg_addr},  32'd0);
      check("rst_reg_wdata", {24'd0, reg_wdata}, 32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_state",     {28'd0, state_dbg}, {28'd0, ST_IDLE});
      res = 1'b1;
      q_wait();

      // burst write
      write_txn(8'h10, 8'ha5, 8'h5a);

      // pointer write, repeated START, two-byte read
      rd0 = rd_seen;
      i2c_start();
      write_byte(8'h7c, ack);
      check("rd_waddr_ack", {31'd0, ack}, 32'd0);
      write_byte(8'h20, ack);
      check("rd_ptr_ack", {31'd0, ack}, 32'd0);
      model_ptr = 8'h20;
      i2c_start();
      write_byte(8'h7d, ack);
      check("rd_raddr_ack", {31'd0, ack}, 32'd0);
      exp_rd_q.push_back(model_ptr ^ 8'hff);
      read_byte(1'b0, rbyte);
      rexp = exp_rd_q.pop_front();
      check("rd_byte0", {24'd0, rbyte}, {24'd0, rexp});
      model_ptr++;
      exp_rd_q.push_back(model_ptr ^ 8'hff);
      read_byte(1'b1, rbyte);
      rexp = exp_rd_q.pop_front();
      check("rd_byte1", {24'd0, rbyte}, {24'd0, rexp});
      check("rd_oe_after_nack", {31'd0, sda_oe}, 32'd0);
      i2c_stop();
      q_wait();
      check("rd_count", rd_seen - rd0, 32'd2);
      check("rd_ptr_after", {24'd0, reg_addr}, {24'd0, model_ptr});
      check("rd_busy_after_stop", {31'd0, busy}, 32'd0);

      // address mismatch
      oe0 = oe_seen; wr0 = wr_seen;
      i2c_start();
      write_byte(8'h7e, ack);
      check("mm_addr_nack", {31'd0, ack}, 32'd1);
      check("mm_busy", {31'd0, busy}, 32'd0);
      write_byte(8'h00, ack);
      check("mm_data_nack", {31'd0, ack}, 32'd1);
      i2c_stop();
      q_wait();
      check("mm_oe_never", oe_seen - oe0, 32'd0);
      check("mm_wr_never", wr_seen - wr0, 32'd0);
      check("mm_state_idle", {28'd0, state_dbg}, {28'd0, ST_IDLE});

      // pointer wrap
      write_txn(8'hff, 8'h11, 8'h22);

      // 2-clk SDA glitch while SCL high
      @(posedge clk); #1;
      m_sda = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_sda = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("glitch_state_idle", {28'd0, state_dbg}, {28'd0, ST_IDLE});
      check("glitch_busy", {31'd0, busy}, 32'd0);

      // reset during the address ACK slot
      i2c_start();
      for (int i = 7; i >= 0; i--) begin
         logic s;
         rexp = 8'h7c;
         send_bit(rexp[i], s);
      end
      m_sda = 1'b1; q_wait();
      m_scl = 1'b1; q_wait();
      check("ack_slot_oe", {31'd0, sda_oe}, 32'd1);
      check("ack_slot_busy", {31'd0, busy}, 32'd1);
      res = 1'b0;
      #1;
      check("mid_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_ptr", {24'd0, reg_addr}, 32'd0);
      q_wait();
      res = 1'b1;
      q_wait();
      q_wait();
      write_txn(8'h40, 8'h33, 8'hc7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
